// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
//   Hazard and sequencing controller for the 5-stage OTTER pipeline
//   (IF/ID/EX/MEM/WB). Produces EX operand forwarding selects, the
//   load-use stall, branch/jump flushes, and runs the interrupt-entry
//   sequence that drains the pipe before redirecting the PC to mtvec.
//
// Ports
//   CLK, RESET          clock, asynchronous active-high reset
//   rs1/rs2_addr_ID     ID-stage source indices; use_rs1/2_ID qualify them
//   rd_addr_EX          EX destination; memRead2_EX marks a load in EX
//   redirect_EX         EX instruction changes the PC
//   rd_addr_MEM, regWrite_MEM, rf_wr_sel_MEM   MEM writeback info (3 = ALU)
//   rd_addr_WB, regWrite_WB                    WB writeback info
//   INTR, mie           level interrupt request and CSR enable
//   fwd_a_sel/fwd_b_sel 0 = RF, 1 = alu_result_MEM, 2 = rfIn (WB)
//   pc_stall            hold the PC
//   if_id_stall         IF_ID holds its value
//   if_id_flush         IF_ID loads a NOP
//   id_ex_flush         ID_EX loads a bubble
//   int_taken           one-cycle strobe: save mepc, select mtvec
//   stall_cnt           saturating count of pc_stall cycles
//
// Interrupt FSM
//   state    | meaning
//   ST_IDLE  | normal operation, hazard logic active
//   ST_DRAIN | bubbles inserted while EX/MEM/WB empty out
//   ST_TAKE  | redirect to mtvec, ID instruction becomes mepc

module pipeline_hazard_ctrl #(
    parameter int DRAIN_CYCLES = 3,
    parameter int CNT_W        = 32
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [4:0]       rs1_addr_ID,
    input  logic [4:0]       rs2_addr_ID,
    input  logic             use_rs1_ID,
    input  logic             use_rs2_ID,
    input  logic [4:0]       rd_addr_EX,
    input  logic             memRead2_EX,
    input  logic             redirect_EX,
    input  logic [4:0]       rd_addr_MEM,
    input  logic             regWrite_MEM,
    input  logic [1:0]       rf_wr_sel_MEM,
    input  logic [4:0]       rd_addr_WB,
    input  logic             regWrite_WB,
    input  logic             INTR,
    input  logic             mie,
    output logic [1:0]       fwd_a_sel,
    output logic [1:0]       fwd_b_sel,
    output logic             pc_stall,
    output logic             if_id_stall,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             int_taken,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [DW-1:0] DRAIN_LOAD = DW'(DRAIN_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_TAKE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [DW-1:0]    drain_q, drain_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [4:0]       rs1_ex_q, rs1_ex_d;
    logic [4:0]       rs2_ex_q, rs2_ex_d;

    logic             load_use;
    logic             pc_stall_c, if_id_stall_c, if_id_flush_c, id_ex_flush_c, int_taken_c;

    // MEM only forwards ALU results; a load still in MEM has no data yet.
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] r,
        input logic       wr_mem,
        input logic [4:0] rd_mem,
        input logic [1:0] sel_mem,
        input logic       wr_wb,
        input logic [4:0] rd_wb
    );
        logic [1:0] s;
        s = 2'd0;
        if (r == 5'd0)
            s = 2'd0;
        else if (wr_mem && (rd_mem == r) && (sel_mem == 2'd3))
            s = 2'd1;
        else if (wr_wb && (rd_wb == r))
            s = 2'd2;
        return s;
    endfunction

    assign load_use = memRead2_EX && (rd_addr_EX != 5'd0) &&
                      ((use_rs1_ID && (rs1_addr_ID == rd_addr_EX)) ||
                       (use_rs2_ID && (rs2_addr_ID == rd_addr_EX)));

    always_comb begin
        state_d       = state_q;
        drain_d       = drain_q;
        pc_stall_c    = 1'b0;
        if_id_stall_c = 1'b0;
        if_id_flush_c = 1'b0;
        id_ex_flush_c = 1'b0;
        int_taken_c   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // Redirect wins: a stalled ID instruction is on the wrong path.
                if (redirect_EX) begin
                    if_id_flush_c = 1'b1;
                    id_ex_flush_c = 1'b1;
                end else if (load_use) begin
                    pc_stall_c    = 1'b1;
                    if_id_stall_c = 1'b1;
                    id_ex_flush_c = 1'b1;
                end
                if (INTR && mie && !redirect_EX && !load_use) begin
                    state_d = ST_DRAIN;
                    drain_d = DRAIN_LOAD;
                end
            end
            ST_DRAIN: begin
                pc_stall_c    = 1'b1;
                if_id_stall_c = 1'b1;
                id_ex_flush_c = 1'b1;
                if (drain_q == '0)
                    state_d = ST_TAKE;
                else
                    drain_d = drain_q - DW'(1);
            end
            ST_TAKE: begin
                int_taken_c   = 1'b1;
                if_id_flush_c = 1'b1;
                id_ex_flush_c = 1'b1;
                state_d       = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // EX source tracking mirrors the ID_EX register: bubble on flush, hold on stall.
    always_comb begin
        rs1_ex_d = rs1_addr_ID;
        rs2_ex_d = rs2_addr_ID;
        if (id_ex_flush_c) begin
            rs1_ex_d = 5'd0;
            rs2_ex_d = 5'd0;
        end else if (if_id_stall_c) begin
            rs1_ex_d = rs1_ex_q;
            rs2_ex_d = rs2_ex_q;
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (pc_stall_c && (stall_cnt_q != {CNT_W{1'b1}}))
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q     <= ST_IDLE;
            drain_q     <= '0;
            stall_cnt_q <= '0;
            rs1_ex_q    <= 5'd0;
            rs2_ex_q    <= 5'd0;
        end else begin
            state_q     <= state_d;
            drain_q     <= drain_d;
            stall_cnt_q <= stall_cnt_d;
            rs1_ex_q    <= rs1_ex_d;
            rs2_ex_q    <= rs2_ex_d;
        end
    end

    assign fwd_a_sel   = fwd_sel(rs1_ex_q, regWrite_MEM, rd_addr_MEM, rf_wr_sel_MEM,
                                 regWrite_WB, rd_addr_WB);
    assign fwd_b_sel   = fwd_sel(rs2_ex_q, regWrite_MEM, rd_addr_MEM, rf_wr_sel_MEM,
                                 regWrite_WB, rd_addr_WB);
    assign pc_stall    = pc_stall_c;
    assign if_id_stall = if_id_stall_c;
    assign if_id_flush = if_id_flush_c;
    assign id_ex_flush = id_ex_flush_c;
    assign int_taken   = int_taken_c;
    assign stall_cnt   = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
module tb_pipeline_hazard_ctrl;

    localparam int CW = 3;  // narrow counter so saturation is reachable

    logic          CLK;
    logic          RESET;
    logic [4:0]    rs1_addr_ID, rs2_addr_ID, rd_addr_EX, rd_addr_MEM, rd_addr_WB;
    logic          use_rs1_ID, use_rs2_ID, memRead2_EX, redirect_EX;
    logic          regWrite_MEM, regWrite_WB, INTR, mie;
    logic [1:0]    rf_wr_sel_MEM;
    logic [1:0]    fwd_a_sel, fwd_b_sel;
    logic          pc_stall, if_id_stall, if_id_flush, id_ex_flush, int_taken;
    logic [CW-1:0] stall_cnt;

    int n_checks = 0;
    int n_errors = 0;

    // {pc_stall, if_id_stall, if_id_flush, id_ex_flush, int_taken}
    logic [4:0] ctl;
    assign ctl = {pc_stall, if_id_stall, if_id_flush, id_ex_flush, int_taken};

    localparam logic [4:0] C_NONE  = 5'b00000;
    localparam logic [4:0] C_STALL = 5'b11010;
    localparam logic [4:0] C_REDIR = 5'b00110;
    localparam logic [4:0] C_TAKE  = 5'b00111;

    pipeline_hazard_ctrl #(.DRAIN_CYCLES(3), .CNT_W(CW)) dut (
        .CLK           (CLK),
        .RESET         (RESET),
        .rs1_addr_ID   (rs1_addr_ID),
        .rs2_addr_ID   (rs2_addr_ID),
        .use_rs1_ID    (use_rs1_ID),
        .use_rs2_ID    (use_rs2_ID),
        .rd_addr_EX    (rd_addr_EX),
        .memRead2_EX   (memRead2_EX),
        .redirect_EX   (redirect_EX),
        .rd_addr_MEM   (rd_addr_MEM),
        .regWrite_MEM  (regWrite_MEM),
        .rf_wr_sel_MEM (rf_wr_sel_MEM),
        .rd_addr_WB    (rd_addr_WB),
        .regWrite_WB   (regWrite_WB),
        .INTR          (INTR),
        .mie           (mie),
        .fwd_a_sel     (fwd_a_sel),
        .fwd_b_sel     (fwd_b_sel),
        .pc_stall      (pc_stall),
        .if_id_stall   (if_id_stall),
        .if_id_flush   (if_id_flush),
        .id_ex_flush   (id_ex_flush),
        .int_taken     (int_taken),
        .stall_cnt     (stall_cnt)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_in();
        rs1_addr_ID = 0; rs2_addr_ID = 0; use_rs1_ID = 0; use_rs2_ID = 0;
        rd_addr_EX = 0; memRead2_EX = 0; redirect_EX = 0;
        rd_addr_MEM = 0; regWrite_MEM = 0; rf_wr_sel_MEM = 0;
        rd_addr_WB = 0; regWrite_WB = 0;
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        RESET = 1'b1; INTR = 1'b0; mie = 1'b0;
        clear_in();
        #3;
        check_val("rst_ctl", 32'(ctl), 32'(C_NONE));
        check_val("rst_fwd_a", 32'(fwd_a_sel), 0);
        check_val("rst_fwd_b", 32'(fwd_b_sel), 0);
        check_val("rst_cnt", 32'(stall_cnt), 0);
        #5 RESET = 1'b0;
        step();
        #1;
        check_val("post_rst_ctl", 32'(ctl), 32'(C_NONE));
        check_val("post_rst_cnt", 32'(stall_cnt), 0);

        // lw x5,0(x1) in EX; add x6,x5,x2 in ID
        rs1_addr_ID = 5; rs2_addr_ID = 2; use_rs1_ID = 1; use_rs2_ID = 1;
        rd_addr_EX = 5; memRead2_EX = 1;
        #1 check_val("lu_ctl", 32'(ctl), 32'(C_STALL));
        step();
        rd_addr_EX = 0; memRead2_EX = 0;
        rd_addr_MEM = 5; regWrite_MEM = 1; rf_wr_sel_MEM = 2;
        #1;
        check_val("lu_bubble_ctl", 32'(ctl), 32'(C_NONE));
        check_val("lu_bubble_fwd_a", 32'(fwd_a_sel), 0);
        check_val("lu_cnt", 32'(stall_cnt), 1);
        step();
        clear_in();
        rd_addr_EX = 6; rd_addr_WB = 5; regWrite_WB = 1;
        #1;
        check_val("lu_fwd_a_wb", 32'(fwd_a_sel), 2);
        check_val("lu_fwd_b", 32'(fwd_b_sel), 0);

        // add x3,x1,x2 in EX; sub x4,x3,x3 in ID
        step();
        clear_in();
        rs1_addr_ID = 3; rs2_addr_ID = 3; use_rs1_ID = 1; use_rs2_ID = 1; rd_addr_EX = 3;
        #1 check_val("alu_dep_ctl", 32'(ctl), 32'(C_NONE));
        step();
        clear_in();
        rd_addr_EX = 4;
        rd_addr_MEM = 3; regWrite_MEM = 1; rf_wr_sel_MEM = 3;
        rd_addr_WB = 3; regWrite_WB = 1;
        #1;
        check_val("mem_fwd_a", 32'(fwd_a_sel), 1);
        check_val("mem_fwd_b", 32'(fwd_b_sel), 1);
        rf_wr_sel_MEM = 2;
        #1 check_val("mem_nonalu_fwd_a", 32'(fwd_a_sel), 2);
        regWrite_WB = 0;
        #1 check_val("no_fwd_a", 32'(fwd_a_sel), 0);

        // add x3; nop; or x7,x3,x0
        step();
        clear_in();
        rs1_addr_ID = 3; rs2_addr_ID = 0; use_rs1_ID = 1; use_rs2_ID = 1;
        step();
        clear_in();
        rd_addr_EX = 7; rd_addr_WB = 3; regWrite_WB = 1;
        #1;
        check_val("wb_fwd_a", 32'(fwd_a_sel), 2);
        check_val("x0_src_fwd_b", 32'(fwd_b_sel), 0);

        // writes to x0 never forward
        step();
        clear_in();
        rd_addr_MEM = 0; regWrite_MEM = 1; rf_wr_sel_MEM = 3;
        rd_addr_WB = 0; regWrite_WB = 1;
        #1;
        check_val("x0_fwd_a", 32'(fwd_a_sel), 0);
        check_val("x0_fwd_b", 32'(fwd_b_sel), 0);

        // load to x0 is not a hazard
        clear_in();
        rs1_addr_ID = 0; use_rs1_ID = 1; rd_addr_EX = 0; memRead2_EX = 1;
        #1 check_val("x0_load_ctl", 32'(ctl), 32'(C_NONE));

        // taken branch together with load-use
        step();
        clear_in();
        rs1_addr_ID = 5; use_rs1_ID = 1; rd_addr_EX = 5; memRead2_EX = 1; redirect_EX = 1;
        #1 check_val("redir_lu_ctl", 32'(ctl), 32'(C_REDIR));
        step();
        clear_in();
        #1 check_val("redir_cnt", 32'(stall_cnt), 1);

        // interrupt entry
        INTR = 1; mie = 1;
        #1 check_val("irq_idle_ctl", 32'(ctl), 32'(C_NONE));
        step();
        mie = 0;
        #1 check_val("drain1_ctl", 32'(ctl), 32'(C_STALL));
        step();
        #1 check_val("drain2_ctl", 32'(ctl), 32'(C_STALL));
        step();
        #1 check_val("drain3_ctl", 32'(ctl), 32'(C_STALL));
        step();
        INTR = 0;
        #1 check_val("take_ctl", 32'(ctl), 32'(C_TAKE));
        step();
        #1;
        check_val("irq_done_ctl", 32'(ctl), 32'(C_NONE));
        check_val("irq_cnt", 32'(stall_cnt), 4);

        // interrupt delayed by redirect, then reset mid-drain
        INTR = 1; mie = 1; redirect_EX = 1;
        #1 check_val("irq_redir_ctl", 32'(ctl), 32'(C_REDIR));
        step();
        redirect_EX = 0;
        #1 check_val("irq_delay_ctl", 32'(ctl), 32'(C_NONE));
        step();
        #1 check_val("irq_late_drain", 32'(ctl), 32'(C_STALL));
        step();
        RESET = 1; INTR = 0; mie = 0;
        #1;
        check_val("rst_mid_ctl", 32'(ctl), 32'(C_NONE));
        check_val("rst_mid_cnt", 32'(stall_cnt), 0);
        step();
        #1 check_val("rst_hold_ctl", 32'(ctl), 32'(C_NONE));
        RESET = 0;
        step();
        step();
        #1;
        check_val("rst_after_ctl", 32'(ctl), 32'(C_NONE));
        check_val("rst_after_cnt", 32'(stall_cnt), 0);

        // long load-use stall saturates the counter; pending INTR must wait
        rs1_addr_ID = 7; use_rs1_ID = 1; rd_addr_EX = 7; memRead2_EX = 1;
        INTR = 1; mie = 1;
        for (int i = 0; i < 9; i++) step();
        #1;
        check_val("sat_ctl", 32'(ctl), 32'(C_STALL));
        check_val("sat_cnt", 32'(stall_cnt), 7);
        clear_in();
        INTR = 0; mie = 0;
        #1 check_val("lu_blocks_irq", 32'(ctl), 32'(C_NONE));
        step();
        #1 check_val("sat_hold_cnt", 32'(stall_cnt), 7);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
